// File: rtl/ifetch_rd_arbiter_if.sv
// Bundle of fetch-requester handshakes and the shared AXI3 read channel.
// master = the arbiter (AXI read master), slave = requesters + AXI slave side.
interface ifetch_rd_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [3:0]  m0_len;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_rlast;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [3:0]  m1_len;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_rlast;

  logic        m2_req;
  logic [31:0] m2_addr;
  logic [3:0]  m2_len;
  logic        m2_gnt;
  logic        m2_rvalid;
  logic [31:0] m2_rdata;
  logic        m2_rlast;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        busy;
  logic [1:0]  owner;

  modport master (
    input  m0_req, m0_addr, m0_len, m1_req, m1_addr, m1_len, m2_req, m2_addr, m2_len,
    output m0_gnt, m0_rvalid, m0_rdata, m0_rlast,
    output m1_gnt, m1_rvalid, m1_rdata, m1_rlast,
    output m2_gnt, m2_rvalid, m2_rdata, m2_rlast,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready, busy, owner
  );

  modport slave (
    output m0_req, m0_addr, m0_len, m1_req, m1_addr, m1_len, m2_req, m2_addr, m2_len,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_rlast,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_rlast,
    input  m2_gnt, m2_rvalid, m2_rdata, m2_rlast,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready, busy, owner
  );
endinterface

// File: rtl/ifetch_rd_arbiter.sv
// Fixed-priority (m0 > m1 > m2) arbiter sharing one AXI3 read port, one burst in flight.
// Optional m2 anti-starvation promotion: define IFETCH_ARB_STARVE_GUARD_EN.
module ifetch_rd_arbiter #(
  parameter int N_REQ        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  ifetch_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [1:0] NO_OWNER = 2'(N_REQ);

  state_t      state;
  logic        arvalid_q;
  logic        rready_q;
  logic        busy_q;
  logic [1:0]  owner_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [3:0]  arlen_q;

  logic        any_req;
  logic [1:0]  pri_idx;
  logic [1:0]  win_idx;
  logic [31:0] sel_addr;
  logic [3:0]  sel_len;
  logic        ar_hs;

`ifdef IFETCH_ARB_STARVE_GUARD_EN
  logic [2:0]  starve_cnt;
`endif

  assign any_req = bus.m0_req | bus.m1_req | bus.m2_req;

  always_comb begin
    if (bus.m0_req)      pri_idx = 2'd0;
    else if (bus.m1_req) pri_idx = 2'd1;
    else                 pri_idx = 2'd2;
    win_idx = pri_idx;
`ifdef IFETCH_ARB_STARVE_GUARD_EN
    // m2 has lost enough times in a row: it jumps the queue once
    if (bus.m2_req && (starve_cnt == 3'(STARVE_LIMIT))) win_idx = 2'd2;
`endif
    case (win_idx)
      2'd0:    begin sel_addr = bus.m0_addr; sel_len = bus.m0_len; end
      2'd1:    begin sel_addr = bus.m1_addr; sel_len = bus.m1_len; end
      default: begin sel_addr = bus.m2_addr; sel_len = bus.m2_len; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= NO_OWNER;
      arid_q    <= 4'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 4'd0;
`ifdef IFETCH_ARB_STARVE_GUARD_EN
      starve_cnt <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ADDR;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            owner_q   <= win_idx;
            arid_q    <= {2'b00, win_idx};
            araddr_q  <= sel_addr;
            arlen_q   <= sel_len;
          end
`ifdef IFETCH_ARB_STARVE_GUARD_EN
          if (!bus.m2_req || (win_idx == 2'd2)) starve_cnt <= 3'd0;
          else                                  starve_cnt <= starve_cnt + 3'd1;
`endif
        end
        ADDR: begin
          if (bus.arready) begin
            state     <= DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        DATA: begin
          // rlast alone closes the burst; beats are not counted
          if (bus.rvalid && bus.rlast) begin
            state    <= IDLE;
            rready_q <= 1'b0;
            busy_q   <= 1'b0;
            owner_q  <= NO_OWNER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ar_hs = arvalid_q & bus.arready;

  assign bus.m0_gnt = ar_hs && (owner_q == 2'd0);
  assign bus.m1_gnt = ar_hs && (owner_q == 2'd1);
  assign bus.m2_gnt = ar_hs && (owner_q == 2'd2);

  // R channel is steered to the owner only while in DATA; everyone else sees zeros
  assign bus.m0_rvalid = rready_q && (owner_q == 2'd0) && bus.rvalid;
  assign bus.m1_rvalid = rready_q && (owner_q == 2'd1) && bus.rvalid;
  assign bus.m2_rvalid = rready_q && (owner_q == 2'd2) && bus.rvalid;
  assign bus.m0_rlast  = rready_q && (owner_q == 2'd0) && bus.rlast;
  assign bus.m1_rlast  = rready_q && (owner_q == 2'd1) && bus.rlast;
  assign bus.m2_rlast  = rready_q && (owner_q == 2'd2) && bus.rlast;
  assign bus.m0_rdata  = (rready_q && (owner_q == 2'd0)) ? bus.rdata : 32'd0;
  assign bus.m1_rdata  = (rready_q && (owner_q == 2'd1)) ? bus.rdata : 32'd0;
  assign bus.m2_rdata  = (rready_q && (owner_q == 2'd2)) ? bus.rdata : 32'd0;

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;

  // rid/rresp are intentionally not inspected
  logic unused_sigs;
`ifdef IFETCH_ARB_STARVE_GUARD_EN
  assign unused_sigs = ^{bus.rid, bus.rresp};
`else
  assign unused_sigs = ^{bus.rid, bus.rresp, 3'(STARVE_LIMIT)};
`endif

endmodule

// File: tb/tb_ifetch_rd_arbiter.sv
// Bench for ifetch_rd_arbiter: vector table, directed corner sequences, random run vs model.
module tb_ifetch_rd_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_rd_arbiter_if bus();
  ifetch_rd_arbiter #(.N_REQ(3), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [2:0]  req;
  logic [31:0] addr [3];
  logic [3:0]  len  [3];
  logic        arready, rvalid, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  assign bus.m0_req = req[0]; assign bus.m0_addr = addr[0]; assign bus.m0_len = len[0];
  assign bus.m1_req = req[1]; assign bus.m1_addr = addr[1]; assign bus.m1_len = len[1];
  assign bus.m2_req = req[2]; assign bus.m2_addr = addr[2]; assign bus.m2_len = len[2];
  assign bus.arready = arready;
  assign bus.rvalid  = rvalid;
  assign bus.rlast   = rlast;
  assign bus.rdata   = rdata;
  assign bus.rresp   = rresp;
  assign bus.rid     = rid;

  logic [2:0]  gnt_v, rv_v, rl_v;
  logic [31:0] rdo [3];
  assign gnt_v = {bus.m2_gnt, bus.m1_gnt, bus.m0_gnt};
  assign rv_v  = {bus.m2_rvalid, bus.m1_rvalid, bus.m0_rvalid};
  assign rl_v  = {bus.m2_rlast, bus.m1_rlast, bus.m0_rlast};
  assign rdo[0] = bus.m0_rdata;
  assign rdo[1] = bus.m1_rdata;
  assign rdo[2] = bus.m2_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req = 3'b000; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rdata = 32'd0; rresp = 2'd0; rid = 4'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rq_rst;
    logic [2:0]  rq;
    logic        ardy, rv, rl;
    logic [31:0] rd;
    logic        e_arv, e_busy;
    logic [1:0]  e_own;
    logic [2:0]  e_gnt, e_rv;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl [11];

  // random-phase reference state (transaction level)
  bit          c_v, c_acc;
  int          c_id;
  logic [31:0] c_addr;
  logic [3:0]  c_len;
  int          s_left;
  int          starve;
  logic [2:0]  pend;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, got, exp_id, n_arb;
    bit ok, drain;

    addr[0] = 32'h1FC0_0380; len[0] = 4'd0;
    addr[1] = 32'h1FC0_0020; len[1] = 4'd7;
    addr[2] = 32'h1FC0_1000; len[2] = 4'd7;

    //          rst rq     ar rv rl rd            arv bsy own   gnt     rv      id
    tbl[0]  = '{0, 3'b000, 0, 0, 0, 32'h0,        0,  0,  2'd3, 3'b000, 3'b000, 2'd0};
    tbl[1]  = '{0, 3'b101, 0, 0, 0, 32'h0,        0,  0,  2'd3, 3'b000, 3'b000, 2'd0};
    tbl[2]  = '{0, 3'b101, 1, 0, 0, 32'h0,        1,  1,  2'd0, 3'b001, 3'b000, 2'd0};
    tbl[3]  = '{0, 3'b100, 0, 1, 1, 32'hB0,       0,  1,  2'd0, 3'b000, 3'b001, 2'd0};
    tbl[4]  = '{0, 3'b100, 0, 0, 0, 32'h0,        0,  0,  2'd3, 3'b000, 3'b000, 2'd0};
    tbl[5]  = '{0, 3'b100, 0, 0, 0, 32'h0,        1,  1,  2'd2, 3'b000, 3'b000, 2'd2};
    tbl[6]  = '{0, 3'b100, 1, 0, 0, 32'h0,        1,  1,  2'd2, 3'b100, 3'b000, 2'd2};
    tbl[7]  = '{0, 3'b000, 0, 1, 0, 32'hC0,       0,  1,  2'd2, 3'b000, 3'b100, 2'd0};
    tbl[8]  = '{0, 3'b000, 0, 0, 0, 32'h0,        0,  1,  2'd2, 3'b000, 3'b000, 2'd0};
    tbl[9]  = '{0, 3'b000, 0, 1, 1, 32'hC1,       0,  1,  2'd2, 3'b000, 3'b100, 2'd0};
    tbl[10] = '{0, 3'b000, 0, 0, 0, 32'h0,        0,  0,  2'd3, 3'b000, 3'b000, 2'd0};

    // ---- table: reset state, m0+m2 collision, gap inside m2 burst
    do_reset();
    check("reset arsize",  32'(bus.arsize), 32'd2);
    check("reset arburst", 32'(bus.arburst), 32'd1);
    check("reset arlen",   32'(bus.arlen), 32'd0);
    check("reset araddr",  bus.araddr, 32'd0);
    check("reset rready",  32'(bus.rready), 32'd0);
    check("reset ar misc", 32'({bus.arlock, bus.arcache, bus.arprot}), 32'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = tbl[i].rq_rst; req = tbl[i].rq; arready = tbl[i].ardy;
      rvalid = tbl[i].rv; rlast = tbl[i].rl; rdata = tbl[i].rd;
      #1;
      check($sformatf("tbl%0d arvalid", i), 32'(bus.arvalid), 32'(tbl[i].e_arv));
      check($sformatf("tbl%0d busy", i),    32'(bus.busy),    32'(tbl[i].e_busy));
      check($sformatf("tbl%0d owner", i),   32'(bus.owner),   32'(tbl[i].e_own));
      check($sformatf("tbl%0d gnt", i),     32'(gnt_v),       32'(tbl[i].e_gnt));
      check($sformatf("tbl%0d rvalid", i),  32'(rv_v),        32'(tbl[i].e_rv));
      check($sformatf("tbl%0d rlast", i),   32'(rl_v),        32'(tbl[i].rl ? tbl[i].e_rv : 3'b000));
      for (int n = 0; n < 3; n++)
        check($sformatf("tbl%0d rdata%0d", i, n), rdo[n], tbl[i].e_rv[n] ? tbl[i].rd : 32'd0);
      if (tbl[i].e_arv) begin
        check($sformatf("tbl%0d arid", i),   32'(bus.arid),  32'(tbl[i].e_id));
        check($sformatf("tbl%0d araddr", i), bus.araddr,     addr[tbl[i].e_id]);
        check($sformatf("tbl%0d arlen", i),  32'(bus.arlen), 32'(len[tbl[i].e_id]));
      end
    end

    // ---- single m1 refill, arready after 2 cycles, 8 beats
    @(negedge clk); idle_inputs(); req = 3'b010; #1;
    check("A idle arvalid", 32'(bus.arvalid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check("A arvalid held", 32'(bus.arvalid), 32'd1);
      check("A no gnt", 32'(gnt_v), 32'd0);
    end
    check("A arid", 32'(bus.arid), 32'd1);
    check("A araddr", bus.araddr, 32'h1FC0_0020);
    check("A arlen", 32'(bus.arlen), 32'd7);
    @(negedge clk); arready = 1'b1; #1;
    check("A gnt", 32'(gnt_v), 32'b010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); arready = 1'b0; req = 3'b000;
      rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = (i == 7); #1;
      check("A m1_rvalid", 32'(rv_v), 32'b010);
      check("A m1_rdata", rdo[1], 32'hA0 + 32'(i));
      check("A other rdata", rdo[0] | rdo[2], 32'd0);
      check("A m1_rlast", 32'(rl_v), (i == 7) ? 32'b010 : 32'd0);
      check("A busy in burst", 32'(bus.busy), 32'd1);
    end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    check("A busy after", 32'(bus.busy), 32'd0);
    check("A owner after", 32'(bus.owner), 32'd3);

    // ---- m0 arrives during m1 beat 3: no preemption
    @(negedge clk); req = 3'b010; #1;
    @(negedge clk); arready = 1'b1; #1;
    check("B m1 gnt", 32'(gnt_v), 32'b010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); arready = 1'b0; req[1] = 1'b0;
      if (i == 3) req[0] = 1'b1;
      rvalid = 1'b1; rdata = 32'h100 + 32'(i); rlast = (i == 7); #1;
      check("B m1 beat", 32'(rv_v), 32'b010);
      check("B owner held", 32'(bus.owner), 32'd1);
      check("B no ar", 32'(bus.arvalid), 32'd0);
    end
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    check("B idle arvalid", 32'(bus.arvalid), 32'd0);
    check("B idle busy", 32'(bus.busy), 32'd0);
    @(negedge clk); arready = 1'b1; #1;
    check("B m0 arvalid", 32'(bus.arvalid), 32'd1);
    check("B m0 arid", 32'(bus.arid), 32'd0);
    check("B m0 gnt", 32'(gnt_v), 32'b001);
    @(negedge clk); arready = 1'b0; req = 3'b000; rvalid = 1'b1; rlast = 1'b1; rdata = 32'hD0; #1;
    check("B m0 rvalid", 32'(rv_v), 32'b001);
    check("B m0 rlast", 32'(rl_v), 32'b001);
    check("B m0 rdata", rdo[0], 32'hD0);

    // ---- m2 burst with rvalid gaps
    @(negedge clk); idle_inputs(); req = 3'b100; #1;
    @(negedge clk); arready = 1'b1; #1;
    check("C m2 gnt", 32'(gnt_v), 32'b100);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); arready = 1'b0; req = 3'b000;
      rvalid = (c % 2 == 0); rdata = 32'hE0 + 32'(c); rlast = rvalid && (c == 14); #1;
      check("C m2 mirrors rvalid", 32'(bus.m2_rvalid), 32'(rvalid));
      check("C m2 rdata", rdo[2], 32'hE0 + 32'(c));
      check("C rready", 32'(bus.rready), 32'd1);
      if (bus.m2_rvalid) seen++;
    end
    check("C beats delivered", 32'(seen), 32'd8);
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    check("C rready after", 32'(bus.rready), 32'd0);

    // ---- reset while AR is pending
    @(negedge clk); req = 3'b010; #1;
    @(negedge clk); #1;
    check("D arvalid before rst", 32'(bus.arvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("D arvalid after rst", 32'(bus.arvalid), 32'd0);
    check("D owner after rst", 32'(bus.owner), 32'd3);
    check("D busy after rst", 32'(bus.busy), 32'd0);
    @(negedge clk); arready = 1'b1; #1;
    check("D rearb arvalid", 32'(bus.arvalid), 32'd1);
    check("D rearb arid", 32'(bus.arid), 32'd1);
    check("D rearb gnt", 32'(gnt_v), 32'b010);
    @(negedge clk); arready = 1'b0; req = 3'b000; rvalid = 1'b1; rlast = 1'b1; #1;
    @(negedge clk); rvalid = 1'b0; rlast = 1'b0; #1;
    check("D done", 32'(bus.busy), 32'd0);

    // ---- m2 held while m1 keeps re-requesting
    do_reset();
    req = 3'b110;
`ifdef IFETCH_ARB_STARVE_GUARD_EN
    n_arb = 5;
`else
    n_arb = 6;
`endif
    for (int k = 1; k <= n_arb; k++) begin
      ok = 1'b0; got = 0;
      for (int w = 0; w < 10 && !ok; w++) begin
        @(negedge clk); arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; #1;
        if (bus.arvalid) begin ok = 1'b1; got = int'(bus.arid); end
      end
      if (!ok) begin
        check("E ar timeout", 32'd0, 32'd1);
        break;
      end
`ifdef IFETCH_ARB_STARVE_GUARD_EN
      exp_id = (k == LIMIT + 1) ? 2 : 1;
`else
      exp_id = 1;
`endif
      check($sformatf("E arb%0d arid", k), 32'(got), 32'(exp_id));
      @(negedge clk); arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
      if (got == 2) req[2] = 1'b0;
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);

    // ---- random traffic against transaction-level model
    do_reset();
    c_v = 0; c_acc = 0; c_id = 0; c_addr = 0; c_len = 0; s_left = 0; starve = 0; pend = 3'b000;
    for (int cyc = 0; cyc < 3300; cyc++) begin
      logic [2:0] e_gnt;
      bit e_ar, e_dat;
      int w;
      drain = (cyc >= 3000);
      @(negedge clk);
      req = pend;
      arready = 1'($urandom_range(0, 1));
      rvalid = (c_v && c_acc && s_left > 0) ? ($urandom_range(0, 2) != 0) : 1'b0;
      rlast = rvalid && (s_left == 1);
      rdata = $urandom; rresp = 2'($urandom); rid = 4'($urandom);
      #1;
      e_ar = c_v && !c_acc;
      e_dat = c_v && c_acc;
      e_gnt = (e_ar && arready) ? (3'b001 << c_id) : 3'b000;
      check("R arvalid", 32'(bus.arvalid), 32'(e_ar));
      check("R busy", 32'(bus.busy), 32'(c_v));
      check("R owner", 32'(bus.owner), c_v ? 32'(c_id) : 32'd3);
      check("R rready", 32'(bus.rready), 32'(e_dat));
      check("R gnt", 32'(gnt_v), 32'(e_gnt));
      for (int n = 0; n < 3; n++) begin
        bool_chk: begin
          bit own;
          own = e_dat && (c_id == n);
          check($sformatf("R m%0d rvalid", n), 32'(rv_v[n]), 32'(own && rvalid));
          check($sformatf("R m%0d rlast", n),  32'(rl_v[n]), 32'(own && rlast));
          check($sformatf("R m%0d rdata", n),  rdo[n], own ? rdata : 32'd0);
        end
      end
      if (e_ar) begin
        check("R arid", 32'(bus.arid), 32'(c_id));
        check("R araddr", bus.araddr, c_addr);
        check("R arlen", 32'(bus.arlen), 32'(c_len));
      end
      // advance model
      if (!c_v) begin
        w = req[0] ? 0 : (req[1] ? 1 : 2);
`ifdef IFETCH_ARB_STARVE_GUARD_EN
        if (req[2] && starve == LIMIT) w = 2;
        if (!req[2] || w == 2) starve = 0;
        else starve = starve + 1;
`endif
        if (req != 3'b000) begin
          c_v = 1; c_acc = 0; c_id = w; c_addr = addr[w]; c_len = len[w];
        end
      end else if (!c_acc) begin
        if (arready) begin
          c_acc = 1; s_left = int'(c_len) + 1; pend[c_id] = 1'b0;
        end
      end else if (rvalid) begin
        s_left--;
        if (rlast) c_v = 0;
      end
      for (int n = 0; n < 3; n++) begin
        if (!pend[n] && !drain && $urandom_range(0, 5) == 0) begin
          pend[n] = 1'b1;
          addr[n] = $urandom & 32'hFFFF_FFFC;
          len[n] = (n == 0) ? 4'd0 : 4'd7;
        end
      end
    end
    check("R drained", 32'({c_v, pend}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifetch_rd_arbiter.md
Name: ifetch_rd_arbiter

Overview:
- Shares one AXI3 read-only master port between three instruction-fetch requesters:
  - m0: uncached fetch, single beat.
  - m1: icache demand refill, 8-beat line.
  - m2: prefetch buffer fill, 8-beat line.
- Sits between the IF-stage fetch agents and the instruction AXI bus.
- Fixed priority m0 > m1 > m2; one transaction outstanding at a time; ownership held from AR issue until the R beat with rlast.

Parameters:
- N_REQ, 3, number of requesters (fixed at 3; index = priority, 0 highest).
- STARVE_LIMIT, 4, consecutive lost arbitrations before m2 is promoted (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mN_req  in  1  request, held high until mN_gnt (N=0,1,2)
- mN_addr  in  32  physical start address, stable while mN_req
- mN_len  in  4  AXI arlen (0 = 1 beat, 7 = 8 beats)
- mN_gnt  out  1  one-cycle pulse on the AR handshake for mN
- mN_rvalid  out  1  data beat for mN
- mN_rdata  out  32  beat data
- mN_rlast  out  1  final beat of mN transaction
- arid  out  4  requester index, zero-extended
- araddr  out  32  latched address
- arlen  out  4  latched len
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  0
- arcache  out  4  0
- arprot  out  3  0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read id
- rdata  in  32  read data
- rresp  in  2  ignored unless noted
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready
- busy  out  1  state != IDLE
- owner  out  2  current owner index; 2'd3 when idle

Behaviour:
- Reset values:
  - arvalid=0, rready=0, all mN_gnt/mN_rvalid/mN_rlast=0, busy=0, owner=3.
  - araddr=0, arlen=0, arid=0, starvation counter=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Pick the lowest-index asserted mN_req.
  - Latch its addr/len/index into araddr/arlen/arid/owner.
  - Next state ADDR. No request → stay IDLE.
  - Selection is registered, so arvalid rises the cycle after req is first seen (1-cycle arbitration latency).
- ADDR:
  - arvalid=1; AR fields stable.
  - On arvalid&&arready: arvalid drops next cycle, mN_gnt pulses that same cycle (combinational from the handshake), next state DATA.
  - Requests arriving during ADDR/DATA do not preempt.
- DATA:
  - rready=1.
  - m[owner]_rvalid = rvalid, m[owner]_rdata = rdata, m[owner]_rlast = rlast, all combinational.
  - Non-owners see rvalid=0 and rdata=0.
  - On rvalid&&rlast → IDLE; a new arbitration may start the following cycle (back-to-back AR requires 1 idle cycle).
- Beat count is not checked; rlast alone terminates the transaction.
- Requester dropping mN_req before gnt: legal only in IDLE (before latch). After latch, the transaction completes and data is delivered regardless.
- Reset mid-transaction:
  - All outputs return to reset values in the next cycle.
  - Outstanding R beats from the slave after reset are absorbed only if rready is high. rready is 0, so the slave must also be reset (bus-wide rst).
- rresp is not inspected.

Optional Feature:
- Macro: IFETCH_ARB_STARVE_GUARD_EN.
- Enabled:
  - A 3-bit counter increments each time a winner is selected in IDLE while m2_req is high and m2 loses.
  - When counter == STARVE_LIMIT, m2 wins the next arbitration regardless of m0/m1, and the counter clears.
  - The counter also clears whenever m2 wins or m2_req is low in IDLE.
- Disabled: pure fixed priority; counter logic absent.

Test Plan:
- Single m1 req, addr 0x1FC0_0020, len 7, arready after 2 cycles:
  - arvalid held 2 cycles, then m1_gnt pulse; arid=1, araddr=0x1FC0_0020, arlen=7.
  - 8 beats 0xA0..0xA7 appear only on m1_rdata; m1_rlast on the 8th beat; busy falls the next cycle.
- m0 (len 0, 0x1FC0_0380) and m2 (len 7) assert in the same cycle:
  - m0 served first (arid=0, one beat, m0_rlast=1).
  - One idle cycle, then m2 AR issued with arid=2.
- m0 asserts while the m1 transaction is in DATA beat 3:
  - No preemption; m1 receives all 8 beats; m0 AR starts the cycle after IDLE is re-entered.
- rvalid gaps (rvalid low every other cycle) during m2 burst:
  - m2_rvalid mirrors rvalid exactly; 8 beats delivered; rready stays 1 throughout DATA.
- rst asserted in ADDR with arvalid=1:
  - Next cycle arvalid=0, owner=3, busy=0.
  - A pending m1_req is re-arbitrated normally after rst drops.
- With IFETCH_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, m2_req held with m1 re-requesting continuously:
  - m2 is granted on the 5th arbitration.
  - Without the macro, m2 is never granted while m1 keeps requesting.
